// File: rtl/p405s_dcu_st_steer_seq.sv
// Store-steering sequencer: accepts one normal/multiple/string store, loads
// the steering control word, then issues one beat per aligned target word
// with SDQ pop, residue capture and byte-enable generation.
module p405s_dcu_st_steer_seq #(
  parameter int unsigned MAX_WORDS = 32,
  parameter int unsigned WCNT_W    = 6
) (
  input  logic              CB,
  input  logic              resetCoreN,
  input  logic              stReqValid,
  output logic              stReqReady,
  input  logic [1:0]        stReqEa,
  input  logic [2:0]        stReqByteCnt,
  input  logic              stReqString,
  input  logic              stReqMultiple,
  input  logic [WCNT_W-1:0] stReqWordCnt,
  input  logic [1:0]        stReqTailBytes,
  input  logic              stReqByteRev,
  input  logic              stReqEndianOvr,
  output logic [9:0]        stSteerCntl,
  output logic              stSteerLoad,
  output logic              sdqPop,
  output logic              adjLoad,
  output logic              beatValid,
  input  logic              beatAccept,
  output logic [3:0]        beatByteEn,
  output logic [WCNT_W-1:0] beatWordIdx,
  output logic              beatLast,
  output logic              stDone,
  output logic              stReqErr,
  input  logic              stFlush
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CTRL = 2'd1,
    BEAT = 2'd2
  } stateT;

  stateT             stateQ, stateD;

  logic [7:0]        reqTot;
  logic [7:0]        reqSrc;
  logic [7:0]        reqBeats;
  logic [1:0]        reqLastLane;
  logic              reqIllegal;
  logic [7:0]        wcExt;
  logic [7:0]        tailExt;
  logic [7:0]        endByte;
  logic              reqTake;

  logic [WCNT_W-1:0] kQ;
  logic [1:0]        eaQ;
  logic [1:0]        lastLaneQ;
  logic [7:0]        srcQ;
  logic [7:0]        beatsQ;
  logic [9:0]        cntlQ;
  logic              doneQ;
  logic              errQ;

  logic [7:0]        kExt;
  logic              inBeat;
  logic              isFirst;
  logic              isLast;
  logic              popOk;
  logic              beatTake;

  // Decode incoming request: total bytes, source words, beats, legality.
  always_comb begin
    wcExt   = 8'(stReqWordCnt);
    tailExt = (stReqTailBytes == 2'd0) ? 8'd4 : {6'd0, stReqTailBytes};
    if (stReqString) begin
      reqTot = ((wcExt - 8'd1) << 2) + tailExt;
    end else if (stReqMultiple) begin
      reqTot = wcExt << 2;
    end else begin
      reqTot = {5'd0, stReqByteCnt};
    end
    reqSrc      = (reqTot + 8'd3) >> 2;
    reqBeats    = ({6'd0, stReqEa} + reqTot + 8'd3) >> 2;
    endByte     = {6'd0, stReqEa} + reqTot - 8'd1;
    reqLastLane = endByte[1:0];
    if (stReqString && stReqMultiple) begin
      reqIllegal = 1'b1;
    end else if (stReqString || stReqMultiple) begin
      reqIllegal = (stReqWordCnt == '0) ||
                   (stReqWordCnt > WCNT_W'(MAX_WORDS));
    end else begin
      reqIllegal = (stReqByteCnt == 3'd0) || (stReqByteCnt > 3'd4);
    end
  end

  assign reqTake  = (stateQ == IDLE) && stReqValid && !reqIllegal;
  assign inBeat   = (stateQ == BEAT);
  assign kExt     = 8'(kQ);
  assign isFirst  = (kQ == '0);
  assign isLast   = (kExt == (beatsQ - 8'd1));
  assign popOk    = (kExt < srcQ);
  // Flush takes priority over a coincident accept.
  assign beatTake = inBeat && beatAccept && !stFlush;

  // State register.
  always_ff @(posedge CB or negedge resetCoreN) begin
    if (!resetCoreN) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: if (reqTake) stateD = CTRL;
      CTRL: stateD = stFlush ? IDLE : BEAT;
      BEAT: begin
        if (stFlush) begin
          stateD = IDLE;
        end else if (beatAccept && isLast) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Request fields, beat counter and the one-cycle done/error pulses.
  always_ff @(posedge CB or negedge resetCoreN) begin
    if (!resetCoreN) begin
      kQ        <= '0;
      eaQ       <= '0;
      lastLaneQ <= '0;
      srcQ      <= '0;
      beatsQ    <= '0;
      cntlQ     <= '0;
      doneQ     <= 1'b0;
      errQ      <= 1'b0;
    end else begin
      doneQ <= beatTake && isLast;
      errQ  <= (stateQ == IDLE) && stReqValid && reqIllegal;
      if (reqTake) begin
        eaQ       <= stReqEa;
        lastLaneQ <= reqLastLane;
        srcQ      <= reqSrc;
        beatsQ    <= reqBeats;
        cntlQ     <= {stReqEa, reqTot[1:0], (reqTot >= 8'd4), 1'b1,
                      stReqString, stReqMultiple, stReqByteRev,
                      stReqEndianOvr};
      end
      if (stateQ == CTRL) begin
        kQ <= '0;
      end else if (beatTake) begin
        kQ <= kQ + 1'b1;
      end
    end
  end

  // Beat outputs and byte-enable masks; first and last masks combine on a single beat.
  always_comb begin
    beatByteEn = '0;
    if (inBeat) begin
      beatByteEn = 4'b1111;
      if (isFirst) beatByteEn = beatByteEn & (4'b1111 << eaQ);
      if (isLast)  beatByteEn = beatByteEn & (4'b1111 >> (2'd3 - lastLaneQ));
    end
  end

  assign stReqReady  = (stateQ == IDLE);
  assign stSteerLoad = (stateQ == CTRL);
  assign stSteerCntl = cntlQ;
  assign beatValid   = inBeat;
  assign beatWordIdx = inBeat ? kQ : '0;
  assign beatLast    = inBeat && isLast;
  assign sdqPop      = beatTake && popOk;
  assign adjLoad     = beatTake && popOk && (eaQ != 2'd0);
  assign stDone      = doneQ;
  assign stReqErr    = errQ;

endmodule
